// File: rtl/digital_lock_pkg.sv
// Shared types and helpers for the parametrised code lock.
// Code vectors hold the first digit in the MSBs.
package digital_lock_pkg;

    typedef enum logic [1:0] {
        ST_ENTRY,
        ST_OPEN,
        ST_LOCKOUT,
        ST_PROGRAM
    } lock_state_t;

    localparam int MAX_CODE_BITS = 64;
    localparam int MAX_DIGIT_W   = 16;

    // Slot i of a packed code, zero-extended to MAX_DIGIT_W; caller narrows it.
    function automatic logic [MAX_DIGIT_W-1:0] code_slot(
        input logic [MAX_CODE_BITS-1:0] code,
        input int                       digit_w,
        input int                       code_len,
        input int                       i
    );
        logic [MAX_CODE_BITS-1:0] shifted;
        logic [MAX_DIGIT_W-1:0]   mask;
        shifted = code >> ((code_len - 1 - i) * digit_w);
        mask    = '1;
        mask    = mask >> (MAX_DIGIT_W - digit_w);
        return shifted[MAX_DIGIT_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter that parks at zero; load has priority over counting.
// zero is combinational from the count register.
module lock_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/digital_lock_param.sv
// Parametrised keypad code lock with failure counting, timed lockout and reprogramming.
// Outputs are registered; a decision on the last digit is visible the following cycle.
module digital_lock_param
    import digital_lock_pkg::*;
#(
    parameter int                           DIGIT_W        = 3,
    parameter int                           CODE_LEN       = 3,
    parameter logic [CODE_LEN*DIGIT_W-1:0]  DEFAULT_CODE   = 9'b011_111_101,
    parameter int                           MAX_FAIL       = 3,
    parameter int                           UNLOCK_CYCLES  = 4,
    parameter int                           LOCKOUT_CYCLES = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          digit_valid,
    input  logic [DIGIT_W-1:0]            digit,
    input  logic                          clear,
    input  logic                          prog_req,
    output logic                          unlocked,
    output logic                          alarm,
    output logic                          prog_mode,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_count
);

    localparam int CODE_W = CODE_LEN * DIGIT_W;
    localparam int FC_W   = $clog2(MAX_FAIL + 1);
    localparam int IDX_W  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int T_MAX  = ((UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES) - 1;
    localparam int T_W    = (T_MAX > 0) ? $clog2(T_MAX + 1) : 1;

    lock_state_t        state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic               mism, mism_n, miss;
    logic [CODE_W-1:0]  code_q, code_n;
    logic [CODE_W-1:0]  shadow, shadow_n;
    logic [FC_W-1:0]    fail_n;
    logic [DIGIT_W-1:0] slot;
    logic               last;
    logic               t_load, t_zero;
    logic [T_W-1:0]     t_value;

    lock_timer #(.W(T_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (t_load),
        .load_value (t_value),
        .zero       (t_zero)
    );

    assign slot = DIGIT_W'(code_slot(MAX_CODE_BITS'(code_q), DIGIT_W, CODE_LEN, int'(idx)));
    assign last = (idx == IDX_W'(CODE_LEN - 1));
    assign miss = mism | (digit != slot);

    always_comb begin
        state_n  = state;
        idx_n    = idx;
        mism_n   = mism;
        code_n   = code_q;
        shadow_n = shadow;
        fail_n   = fail_count;
        t_load   = 1'b0;
        t_value  = '0;
        case (state)
            ST_ENTRY: begin
                if (clear) begin
                    idx_n  = '0;
                    mism_n = 1'b0;
                end else if (digit_valid) begin
                    if (last) begin
                        idx_n  = '0;
                        mism_n = 1'b0;
                        if (!miss) begin
                            state_n = ST_OPEN;
                            fail_n  = '0;
                            t_load  = 1'b1;
                            t_value = T_W'(UNLOCK_CYCLES - 1);
                        end else if (int'(fail_count) + 1 < MAX_FAIL) begin
                            fail_n = fail_count + FC_W'(1);
                        end else begin
                            state_n = ST_LOCKOUT;
                            fail_n  = FC_W'(MAX_FAIL);
                            t_load  = 1'b1;
                            t_value = T_W'(LOCKOUT_CYCLES - 1);
                        end
                    end else begin
                        idx_n  = idx + IDX_W'(1);
                        mism_n = miss;
                    end
                end
            end
            ST_OPEN: begin
                // Reprogramming beats the timeout, even on the final open cycle.
                if (prog_req) begin
                    state_n = ST_PROGRAM;
                    idx_n   = '0;
                end else if (t_zero) begin
                    state_n = ST_ENTRY;
                end
            end
            ST_PROGRAM: begin
                if (clear) begin
                    state_n = ST_ENTRY;
                    idx_n   = '0;
                end else if (digit_valid) begin
                    for (int i = 0; i < CODE_LEN; i++) begin
                        if (idx == IDX_W'(i)) begin
                            shadow_n[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W] = digit;
                        end
                    end
                    if (last) begin
                        code_n  = shadow_n;
                        state_n = ST_ENTRY;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx + IDX_W'(1);
                    end
                end
            end
            ST_LOCKOUT: begin
                if (t_zero) begin
                    state_n = ST_ENTRY;
                    fail_n  = '0;
                    idx_n   = '0;
                    mism_n  = 1'b0;
                end
            end
            default: state_n = ST_ENTRY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_ENTRY;
            idx        <= '0;
            mism       <= 1'b0;
            code_q     <= DEFAULT_CODE;
            shadow     <= '0;
            fail_count <= '0;
            unlocked   <= 1'b0;
            alarm      <= 1'b0;
            prog_mode  <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            mism       <= mism_n;
            code_q     <= code_n;
            shadow     <= shadow_n;
            fail_count <= fail_n;
            unlocked   <= (state_n == ST_OPEN);
            alarm      <= (state_n == ST_LOCKOUT);
            prog_mode  <= (state_n == ST_PROGRAM);
        end
    end

endmodule

// File: doc/digital_lock_param.md
Name: digital_lock_param

Overview:
Parametrised keypad-style code lock, the successor to the fixed 3-digit lock FSM. The code length and digit width are configurable. Digits are qualified by a valid strobe rather than sampled every cycle. The code is reprogrammable while open. Failed attempts are counted and trigger a timed lockout with an alarm. The block sits between the keypad debouncer/encoder and the actuator/alarm drivers.

Parameters:
DIGIT_W, 3, width of one entered digit.
CODE_LEN, 3, digits per code (>=1).
DEFAULT_CODE, 9'b011_111_101, reset code, CODE_LEN*DIGIT_W bits, first digit in MSBs.
MAX_FAIL, 3, consecutive failed attempts that trigger lockout (>=1).
UNLOCK_CYCLES, 4, cycles unlocked stays high after a correct code (>=1).
LOCKOUT_CYCLES, 8, cycles alarm/lockout lasts (>=1).

Ports:
clk  input  1  single clock, all logic on rising edge
reset  input  1  synchronous, active-high
digit_valid  input  1  digit is presented this cycle
digit  input  DIGIT_W  entered digit
clear  input  1  abort current entry/programming, no failure counted
prog_req  input  1  request code reprogramming (honoured only in OPEN)
unlocked  output  1  lock open
alarm  output  1  lockout active
prog_mode  output  1  programming in progress
fail_count  output  $clog2(MAX_FAIL+1)  consecutive failed attempts

Behaviour:
- Reset (synchronous, active-high, wins over everything): state=ENTRY, digit index=0, mismatch flag=0, code register=DEFAULT_CODE, timer=0. Outputs: unlocked=0, alarm=0, prog_mode=0, fail_count=0. Reset during any state, including LOCKOUT and PROGRAM, discards the state immediately.
- All outputs are registered.
- ENTRY:
  - Each digit_valid cycle compares digit with code slot[idx], ORs any difference into the mismatch flag, and increments idx.
  - A wrong digit does NOT restart the entry early: the whole CODE_LEN sequence is always consumed, so no per-digit information leaks.
  - Idle cycles between digits are allowed; there is no entry timeout.
- On acceptance of the CODE_LEN-th digit (idx and mismatch flag clear on the same edge):
  - Match: go to OPEN, unlocked=1 from the next cycle, fail_count=0, timer loaded with UNLOCK_CYCLES-1.
  - Mismatch with fail_count+1 < MAX_FAIL: stay in ENTRY, fail_count+1.
  - Mismatch with fail_count+1 == MAX_FAIL: go to LOCKOUT, alarm=1, fail_count=MAX_FAIL, timer loaded with LOCKOUT_CYCLES-1.
- clear in ENTRY: idx=0, mismatch=0, fail_count unchanged. If clear and digit_valid occur in the same cycle, clear wins and the digit is discarded.
- OPEN:
  - unlocked is high for exactly UNLOCK_CYCLES cycles. When the timer reaches 0, go to ENTRY with unlocked=0.
  - digit_valid and clear are ignored.
  - prog_req in any OPEN cycle (including the last) has priority over the timeout: go to PROGRAM, unlocked=0, prog_mode=1, idx=0.
- PROGRAM:
  - Each digit_valid writes the digit into shadow slot[idx].
  - After CODE_LEN digits, the code register is loaded from the shadow atomically; go to ENTRY with prog_mode=0.
  - clear aborts: code register unchanged, go to ENTRY, prog_mode=0. clear wins over a simultaneous digit_valid.
  - No timeout.
- LOCKOUT:
  - alarm is high for exactly LOCKOUT_CYCLES cycles.
  - digit_valid, clear and prog_req are all ignored.
  - On exit: go to ENTRY, alarm=0, fail_count=0, idx=0.
- prog_req outside OPEN is ignored.
- The timer is wide enough for max(UNLOCK_CYCLES, LOCKOUT_CYCLES)-1. fail_count saturates at MAX_FAIL and never wraps.

Decomposition:
- Package digital_lock_pkg holds:
  - typedef enum lock_state_t {ST_ENTRY, ST_OPEN, ST_LOCKOUT, ST_PROGRAM};
  - a helper function returning code slot i from a packed code vector.
- One natural sub-module, lock_timer: a loadable down-counter with load, load_value and zero flag, parametrised by width. It is shared by OPEN and LOCKOUT.

Test Plan:
(All with default parameters.)
- Correct code: reset, then digits 3,7,5 with valid on consecutive cycles -> unlocked=1 for exactly 4 cycles starting the cycle after digit 5 is accepted; fail_count=0; repeat with 2 idle cycles between digits gives the same result.
- Wrong-then-right: enter 3,7,4 -> unlocked stays 0, fail_count=1; then 0,7,5 (wrong first digit) -> full 3 digits consumed, fail_count=2; then 3,7,5 -> unlock, fail_count=0.
- Lockout: three wrong codes -> alarm=1 for 8 cycles, fail_count=3; digits 3,7,5 entered during the alarm are ignored; after alarm drops fail_count=0 and 3,7,5 unlocks.
- Reprogram: unlock, pulse prog_req on cycle 2 of OPEN -> unlocked=0, prog_mode=1; enter 1,2,0 -> prog_mode=0; 3,7,5 now fails (fail_count=1); 1,2,0 unlocks; reset restores 3,7,5.
- Clear semantics: enter 3,7 then clear -> no failure, idx restarts, 3,7,5 unlocks. clear together with digit_valid -> digit discarded. clear during PROGRAM after 1,2 -> old code retained.
- Reset mid-operation: assert reset during cycle 3 of LOCKOUT and again in PROGRAM -> all outputs 0 next cycle, state ENTRY, code=DEFAULT_CODE.
